prog_clock_divider: RTL

Parametrised, runtime-programmable integer clock divider; successor to the fixed ÷2/÷4/÷8/÷16 divider. Generates one divided clock for any ratio N in 2..2^CNT_W−1, plus a one-cycle period-start strobe. A load/busy handshake applies ratio changes only at period boundaries, so no runt pulses appear. Sits in the clocking/timing block and feeds downstream enables and slow-clock consumers.

---
 rtl/prog_clock_divider.sv | 103 ++++++++++
 1 files changed

// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider with a period-start tick and a load/busy ratio handshake.
// Optional build macro ODD50_DUTY_EN adds a negedge flop so odd ratios get an exact 50% duty cycle.
module prog_clock_divider #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             load,
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_RATIO = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pending;
  logic             running;
  logic             hi_q;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] half;
  logic             start;
  logic             apply;
  logic             load_ok;

  // A period starts on the wrap edge, or on the first enabled edge after reset or an idle stretch.
  always_comb begin
    cnt_inc  = cnt + CNT_W'(1);
    last_cnt = cur_div - CNT_W'(1);
    half     = CNT_W'(({1'b0, cur_div} + (CNT_W+1)'(1)) >> 1);
    start    = !running || (cnt == last_cnt);
    apply    = busy && (!en || start);
    load_ok  = load && (div_val >= MIN_RATIO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pending <= DEF_RATIO;
      running <= 1'b0;
      hi_q    <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      cur_div <= DEF_RATIO;
    end else begin
      err <= load && !load_ok;

      if (!en) begin
        cnt     <= '0;
        hi_q    <= 1'b0;
        tick    <= 1'b0;
        running <= 1'b0;
      end else if (start) begin
        cnt     <= '0;
        hi_q    <= 1'b1;
        tick    <= 1'b1;
        running <= 1'b1;
      end else begin
        cnt     <= cnt_inc;
        hi_q    <= (cnt_inc < half);
        tick    <= 1'b0;
      end

      // The old pending ratio is consumed before a coincident load overwrites it.
      if (apply) begin
        cur_div <= pending;
        busy    <= 1'b0;
      end

      if (load_ok) begin
        pending <= div_val;
        busy    <= 1'b1;
      end
    end
  end

`ifdef ODD50_DUTY_EN
  logic hi_n;

  // Half-cycle-delayed copy of the high phase trims the extra half cycle off odd ratios.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      hi_n <= 1'b0;
    end else begin
      hi_n <= hi_q;
    end
  end

  assign div_clk = hi_q & (hi_n | ~cur_div[0]);
`else
  assign div_clk = hi_q;
`endif

endmodule
